// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed at issue and committed after a fixed latency.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MD_Control,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   tmp_hi, tmp_hi_n;
    logic [31:0]   tmp_lo, tmp_lo_n;
    logic [31:0]   hi_n, lo_n;
    logic          commit, commit_n;

    logic op_mult, op_multu, op_div, op_divu;
    logic op_mtlo, op_mthi, op_mflo, op_mfhi;
    logic is_mul, is_div;

    assign op_mult  = (MD_Control == 4'd0);
    assign op_multu = (MD_Control == 4'd1);
    assign op_div   = (MD_Control == 4'd2);
    assign op_divu  = (MD_Control == 4'd3);
    assign op_mtlo  = (MD_Control == 4'd4);
    assign op_mthi  = (MD_Control == 4'd5);
    assign op_mflo  = (MD_Control == 4'd6);
    assign op_mfhi  = (MD_Control == 4'd7);
    assign is_mul   = op_mult | op_multu;
    assign is_div   = op_div | op_divu;

    assign Busy  = (state == RUN);
    assign Start = (is_mul | is_div) & ~Busy;

    always_comb begin
        MD_out = 32'd0;
        if (op_mfhi)
            MD_out = HI;
        else if (op_mflo)
            MD_out = LO;
    end

    // Signed divide is done on magnitudes so INT_MIN / -1 wraps cleanly.
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [31:0] q_res, r_res;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    assign a_neg = op_div & A[31];
    assign b_neg = op_div & B[31];
    assign a_mag = a_neg ? (~A + 32'd1) : A;
    assign b_mag = b_neg ? (~B + 32'd1) : B;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    assign q_res = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign r_res = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        tmp_hi_n = tmp_hi;
        tmp_lo_n = tmp_lo;
        hi_n     = HI;
        lo_n     = LO;
        commit_n = commit;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_n = RUN;
                    if (is_mul) begin
                        cnt_n    = CW'(MULT_CYCLES);
                        tmp_hi_n = op_mult ? prod_s[63:32] : prod_u[63:32];
                        tmp_lo_n = op_mult ? prod_s[31:0] : prod_u[31:0];
                        commit_n = 1'b1;
                    end else begin
                        cnt_n    = CW'(DIV_CYCLES);
                        tmp_hi_n = r_res;
                        tmp_lo_n = q_res;
                        commit_n = (B != 32'd0);
                    end
                end else if (op_mtlo) begin
                    lo_n = A;
                end else if (op_mthi) begin
                    hi_n = A;
                end
            end
            RUN: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    if (commit) begin
                        hi_n = tmp_hi;
                        lo_n = tmp_lo;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            tmp_hi <= 32'd0;
            tmp_lo <= 32'd0;
            HI     <= 32'd0;
            LO     <= 32'd0;
            commit <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            tmp_hi <= tmp_hi_n;
            tmp_lo <= tmp_lo_n;
            HI     <= hi_n;
            LO     <= lo_n;
            commit <= commit_n;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic, div-by-zero,
// async reset and back-to-back hand-off.
module tb_md_unit;

    localparam logic [3:0] NONE = 4'hF;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_control;
    logic [31:0] a, b;
    logic        start, busy;
    logic [31:0] hi, lo, md_out;

    int checks = 0;
    int failures = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset(reset),
        .MD_Control(md_control),
        .A(a),
        .B(b),
        .Start(start),
        .Busy(busy),
        .HI(hi),
        .LO(lo),
        .MD_out(md_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue an op from idle, check Start, then check Busy for n cycles.
    task automatic run_op(input logic [3:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input int n,
                          input string tag);
        md_control = op;
        a = av;
        b = bv;
        #1;
        check({tag, "_start"}, {31'd0, start}, 32'd1);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        step();
        md_control = NONE;
        #1;
        check({tag, "_start_low"}, {31'd0, start}, 32'd0);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            step();
        end
        check({tag, "_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        md_control = NONE;
        a = 32'd0;
        b = 32'd0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_mdout", md_out, 32'd0);
        reset = 1'b0;
        step();

        run_op(4'd0, 32'hFFFFFFFE, 32'd3, 5, "mult");
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);
        md_control = 4'd6;
        #1;
        check("mult_mflo", md_out, 32'hFFFFFFFA);
        md_control = NONE;
        step();

        run_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, "multu");
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);

        run_op(4'd2, 32'hFFFFFFF8, 32'd3, 10, "div");
        check("div_lo", lo, 32'hFFFFFFFE);
        check("div_hi", hi, 32'hFFFFFFFE);

        run_op(4'd3, 32'hFFFFFFF8, 32'd3, 10, "divu");
        check("divu_lo", lo, 32'h55555552);
        check("divu_hi", hi, 32'h00000002);

        run_op(4'd2, 32'h80000000, 32'hFFFFFFFF, 10, "divov");
        check("divov_lo", lo, 32'h80000000);
        check("divov_hi", hi, 32'h00000000);

        // Divide by zero preserves HI/LO.
        md_control = 4'd5;
        a = 32'h11111111;
        step();
        md_control = 4'd4;
        a = 32'h22222222;
        step();
        md_control = 4'd7;
        #1;
        check("mthi_mfhi", md_out, 32'h11111111);
        md_control = 4'd6;
        #1;
        check("mtlo_mflo", md_out, 32'h22222222);

        md_control = 4'd2;
        a = 32'd100;
        b = 32'd0;
        #1;
        check("dz_start", {31'd0, start}, 32'd1);
        step();
        md_control = NONE;
        for (int i = 0; i < 10; i++) begin
            check("dz_busy", {31'd0, busy}, 32'd1);
            if (i == 2) begin
                $display("protocol: mult presented while Busy (expect ignore)");
                md_control = 4'd0;
                a = 32'd3;
                b = 32'd4;
                #1;
                check("dz_proto_start", {31'd0, start}, 32'd0);
            end
            step();
            md_control = NONE;
        end
        check("dz_done", {31'd0, busy}, 32'd0);
        check("dz_hi", hi, 32'h11111111);
        check("dz_lo", lo, 32'h22222222);
        step();
        check("dz_no_late", {31'd0, busy}, 32'd0);

        // Reset three cycles into a divide.
        md_control = 4'd2;
        a = 32'd50;
        b = 32'd7;
        step();
        md_control = NONE;
        step();
        step();
        check("rmid_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("rmid_busy", {31'd0, busy}, 32'd0);
        check("rmid_hi", hi, 32'd0);
        check("rmid_lo", lo, 32'd0);
        reset = 1'b0;
        step();
        run_op(4'd0, 32'd7, 32'd6, 5, "mult76");
        check("mult76_lo", lo, 32'd42);
        check("mult76_hi", hi, 32'd0);
        step();

        // Back-to-back hand-off.
        run_op(4'd0, 32'd2, 32'd2, 5, "b2b");
        md_control = 4'd6;
        #1;
        check("b2b_mflo", md_out, 32'd4);
        step();
        md_control = 4'd4;
        a = 32'h0000ABCD;
        step();
        md_control = 4'd6;
        #1;
        check("b2b_mtlo", md_out, 32'h0000ABCD);
        md_control = NONE;
        step();
        run_op(4'd1, 32'd5, 32'd5, 5, "b2b2");
        run_op(4'd3, 32'd25, 32'd4, 10, "b2bdiv");
        check("b2bdiv_lo", lo, 32'd6);
        check("b2bdiv_hi", hi, 32'd1);

        md_control = 4'hA;
        a = 32'hDEADBEEF;
        step();
        check("unused_hi", hi, 32'd1);
        check("unused_lo", lo, 32'd6);
        check("unused_mdout", md_out, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with its own sequencer, sitting in the E stage beside the ALU.
- Decodes the 4-bit MD_Control code emitted by the control unit.
- Owns the HI/LO registers and times the mult/div latency with a down-counter.
- Exports Start/Busy so the hazard unit can stall md/mt/mf instructions in D while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, Busy duration for mult/multu (must be >= 1).
- DIV_CYCLES, 10, Busy duration for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- MD_Control  input  4  E-stage op code. Encoding: 0 mult, 1 multu, 2 div, 3 divu, 4 mtlo, 5 mthi, 6 mflo, 7 mfhi; 4'b1111 = none; all other values are treated as none.
- A  input  32  forwarded rs value for the E-stage instruction.
- B  input  32  forwarded rt value for the E-stage instruction.
- Start  output  1  combinational; 1 when MD_Control is mult/multu/div/divu and Busy==0.
- Busy  output  1  registered; 1 while an operation is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.
- MD_out  output  32  combinational; HI for mfhi, LO for mflo, 0 otherwise.

Behaviour:
- Reset clears HI, LO, Busy, the counter and the temp result registers immediately; Start and MD_out follow combinationally. One clock is one cycle. The async active-high reset is fixed.
- Reset mid-operation:
  - The in-flight result is discarded.
  - HI/LO read 0.
  - Busy deasserts without waiting for a clock edge.
- State machine: IDLE (Busy=0), RUN (Busy=1).
- IDLE, Start=1, at the clock edge:
  - Compute the result into tmp_hi/tmp_lo.
  - cnt <= MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu).
  - Busy <= 1; go to RUN.
- RUN, each edge: cnt <= cnt-1.
- RUN, at the edge where cnt==1:
  - HI <= tmp_hi, LO <= tmp_lo.
  - Busy <= 0; go to IDLE.
- Timing: Busy is high for exactly N cycles after the Start cycle. New HI/LO are visible in the same cycle Busy first reads 0.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 -> 64.
  - div: signed, quotient truncates toward zero; LO=quotient, HI=remainder, with remainder sign = dividend sign.
  - divu: unsigned; LO=quotient, HI=remainder.
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B==0, div or divu): the sequence still runs the full DIV_CYCLES with Busy asserted, but HI/LO keep their old values at completion.
- mtlo/mthi, only when Busy==0: LO<=A or HI<=A at the next edge. MD_out reflects the new value from the following cycle.
- Any md/mt op presented while Busy==1:
  - It is ignored: no state change and Start=0.
  - The hazard unit guarantees this never happens; the bench must flag it as a protocol error.
- mflo/mfhi are combinational reads with no side effects. They are legal in any cycle, but return stale data while Busy==1; the hazard unit stalls them on Start|Busy.
- Non-md codes (1111 and unused values) have no effect.

Test Plan:
- mult, A=0xFFFFFFFE (-2), B=3 -> Start=1 for one cycle; Busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, and mflo gives MD_out=0xFFFFFFFA.
- multu, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 Busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- div, A=0xFFFFFFF8 (-8), B=3 -> Busy=1 for 10 cycles; then LO=0xFFFFFFFE, HI=0xFFFFFFFE. divu with the same operands -> LO=0x55555552, HI=0x00000002.
- Divide by zero:
  - Preload with mthi 0x11111111 and mtlo 0x22222222.
  - Issue div with B=0 -> Busy=1 for 10 cycles; HI/LO unchanged.
  - Then issue mult 3*4 while Busy=1 -> Start=0 and the op is ignored.
- Assert reset at cycle 3 of a div -> Busy, HI and LO read 0 immediately. A mult 7*6 issued after reset -> LO=42 after 5 Busy cycles.
- Back-to-back:
  - mult 2*2, then a mflo presented the cycle Busy drops -> MD_out=4.
  - mtlo 0xABCD the next cycle -> mflo reads 0xABCD.
  - div issued the cycle Busy drops -> Start=1 immediately.
